id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter RA_W, default 5, register-number width.
REQ-003 SHALL have ports `clk` and `reset`, listed in that order, ahead of all other ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high.
REQ-004 SHALL have the following ID-side inputs:
- `id_valid`  input  1  ID slot holds a real instruction.
- `id_opcode`  input  6  instruction opcode.
- `id_rs`, `id_rt`, `id_rd`  input  RA_W each  register numbers.
- `id_rs_data`, `id_rt_data`  input  DATA_W each  register-file read data.
- `id_ext_imm`  input  DATA_W  zero- or sign-extended immediate from the immediate extend unit.
- `id_ctrl`  input  8  control bundle; bit0 RegWrite, 1 MemRead, 2 MemWrite, 3 MemtoReg, 4 ALUSrc, 5 RegDst, 6 Branch, 7 Jump.
REQ-005 SHALL have the following pipeline-control inputs:
- `flush`  input  1  taken branch/jump resolved downstream; kill the ID instruction.
- `stall_ex`  input  1  EX cannot accept; hold all state.
REQ-006 SHALL have outputs `ex_valid`, `ex_opcode`, `ex_rs`, `ex_rt`, `ex_rd`, `ex_rs_data`, `ex_rt_data`, `ex_ext_imm` and `ex_ctrl`, each registered, with the same width as its id_ counterpart.
REQ-007 SHALL have output `hold_id`  1  combinational request to freeze the PC and the IF/ID register.
REQ-008 SHALL have output `bubble_cnt`  16  registered count of load-use bubbles inserted.

Function
REQ-009 SHALL evaluate the following per-cycle priorities, highest first: reset, flush, stall_ex, load_use, capture.
REQ-010 SHALL compute load_use = ex_valid & ex_ctrl[1] & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt).
REQ-011 On capture (no higher event), SHALL load every ex_ field from its id_ counterpart at the next edge (latency 1).
REQ-012 On flush, SHALL clear ex_valid and ex_ctrl to 0 and leave the other ex_ fields unchanged; bubble_cnt SHALL NOT increment.
REQ-013 On stall_ex (no flush), SHALL hold every ex_ register and bubble_cnt.
REQ-014 On load_use (no flush, no stall_ex), SHALL insert a bubble: ex_valid and ex_ctrl go to 0, the other ex_ fields hold, and bubble_cnt increments.
REQ-015 A load_use bubble SHALL last exactly one cycle: the bubble clears ex_valid, so load_use deasserts and the held ID instruction is captured on the following edge.
REQ-016 SHALL drive hold_id = !flush & (stall_ex | load_use); hold_id SHALL be 0 during reset.
REQ-017 bubble_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-018 A bubble (ex_valid = 0) SHALL never have a nonzero ex_ctrl bit.
REQ-019 Comparisons against register 0 SHALL never raise load_use.

Reset
REQ-020 While reset = 1 at a rising edge, SHALL clear every ex_ output and bubble_cnt to 0; reset SHALL override flush and stall_ex.
REQ-021 On the first edge after reset deasserts, SHALL behave per REQ-009..REQ-019, with no residual hold.
REQ-022 Reset asserted mid-bubble or mid-stall SHALL discard that state, with no carry-over.

Structure
REQ-023 A shared pipeline package SHALL hold:
- the ctrl bit-index constants and CTRL_W = 8;
- opcode constants (LW = 6'b100011, SW = 6'b101011, ORI = 6'b001101);
- DATA_W and RA_W defaults.
REQ-024 Load-use detection SHALL be a separate combinational sub-module `hazard_detect` (inputs ex_valid, ex_memread, ex_rt, id_valid, id_rs, id_rt; output load_use).
REQ-025 The top level SHALL contain only the registers, the priority mux and the saturating counter.

Verification
REQ-026 Capture scenario: id_valid = 1, id_ext_imm = 32'hFFFF8000, id_ctrl = 8'h11, no stall or flush.
- One edge later: ex_ext_imm = 32'hFFFF8000, ex_ctrl = 8'h11, ex_valid = 1, hold_id = 0.
REQ-027 Load-use scenario: LW rt = 8 in EX (ex_ctrl[1] = 1); ID instruction with rs = 8.
- hold_id = 1 in that cycle.
- Next edge: ex_valid = 0, ex_ctrl = 0, bubble_cnt = 1.
- Following edge: the ID instruction is captured and hold_id = 0.
REQ-028 Register-zero scenario: LW rt = 0 in EX; ID rs = 0.
- load_use = 0, hold_id = 0, normal capture, bubble_cnt unchanged.
REQ-029 Flush-over-stall scenario: flush = 1 and stall_ex = 1 together with load_use true.
- Next edge: ex_valid = 0, ex_ctrl = 0, bubble_cnt unchanged, hold_id = 0 in that cycle.
REQ-030 Stall then reset scenario: stall_ex = 1 for 3 cycles.
- All ex_ fields hold for those cycles and hold_id = 1.
- Then reset = 1 for one edge: all outputs = 0.
REQ-031 Saturation scenario: preload bubble_cnt to 16'hFFFE via repeated load-use, then trigger two more.
- bubble_cnt = 16'hFFFF after each and stays there.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, opcodes and
// default datapath widths used by the ID/EX stage register and its hazard unit.
package id_ex_reg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 5;
  localparam int OPC_W      = 6;
  localparam int CTRL_W     = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_JUMP     = 7;

  localparam logic [OPC_W-1:0] LW  = 6'b100011;
  localparam logic [OPC_W-1:0] SW  = 6'b101011;
  localparam logic [OPC_W-1:0] ORI = 6'b001101;
endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID
// instruction. Register 0 never creates a dependency.
module hazard_detect
  import id_ex_reg_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  output logic            load_use
);
  logic w_rt_match;
  logic w_rt_nonzero;

  assign w_rt_nonzero = (ex_rt != '0);
  assign w_rt_match   = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign load_use     = ex_valid & ex_memread & w_rt_nonzero & id_valid & w_rt_match;
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall and one-cycle load-use bubble
// insertion, plus a saturating count of inserted bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_ext_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              stall_ex,
  output logic              ex_valid,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_ext_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hold_id,
  output logic [15:0]       bubble_cnt
);
  logic              r_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [RA_W-1:0]   r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_ext_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_bubble_cnt;
  logic              w_load_use;

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .ex_valid   (r_valid),
    .ex_memread (r_ctrl[CTRL_MEMREAD]),
    .ex_rt      (r_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_ext_imm    <= '0;
      r_ctrl       <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (stall_ex) begin
      r_valid <= r_valid;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end else begin
      r_valid   <= id_valid;
      r_opcode  <= id_opcode;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_ext_imm <= id_ext_imm;
      // An empty slot must never carry live control bits into EX.
      r_ctrl    <= id_valid ? id_ctrl : '0;
    end
  end

  assign hold_id    = !reset & !flush & (stall_ex | w_load_use);
  assign ex_valid   = r_valid;
  assign ex_opcode  = r_opcode;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;
  assign ex_rs_data = r_rs_data;
  assign ex_rt_data = r_rt_data;
  assign ex_ext_imm = r_ext_imm;
  assign ex_ctrl    = r_ctrl;
  assign bubble_cnt = r_bubble_cnt;
endmodule
